// File: rtl/display_pkg.sv
// Shared display definitions: message length, character codes, the message ROM
// and active-low seven-segment patterns ordered {g,f,e,d,c,b,a}.
package display_pkg;

    localparam int unsigned MSG_LEN = 12;
    localparam int unsigned WIN_W   = 4;
    localparam int unsigned SEG_W   = 7;

    typedef enum logic [3:0] {
        CH_BLANK = 4'd0,
        CH_H     = 4'd1,
        CH_E     = 4'd2,
        CH_L     = 4'd3,
        CH_O     = 4'd4,
        CH_F     = 4'd5,
        CH_P     = 4'd6,
        CH_G     = 4'd7,
        CH_A     = 4'd8,
        CH_DASH  = 4'd9
    } char_code_e;

    localparam logic [SEG_W-1:0] SEG_H     = 7'b0001001;
    localparam logic [SEG_W-1:0] SEG_E     = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG_L     = 7'b1000111;
    localparam logic [SEG_W-1:0] SEG_O     = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_F     = 7'b0001110;
    localparam logic [SEG_W-1:0] SEG_P     = 7'b0001100;
    localparam logic [SEG_W-1:0] SEG_G     = 7'b1000010;
    localparam logic [SEG_W-1:0] SEG_A     = 7'b0001000;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_DASH  = 7'b0111111;

    // "HELLO FPGA  "
    localparam char_code_e MSG [MSG_LEN] = '{
        CH_H, CH_E, CH_L, CH_L, CH_O, CH_BLANK,
        CH_F, CH_P, CH_G, CH_A, CH_BLANK, CH_BLANK
    };

endpackage

// File: rtl/char_seg_decoder.sv
// Combinational character-code to active-low seven-segment pattern decoder.
module char_seg_decoder
    import display_pkg::*;
(
    input  char_code_e         i_code,
    output logic [SEG_W-1:0]   o_seg_c
);

    // Codes outside the table render blank.
    always_comb begin
        o_seg_c = SEG_BLANK;
        case (i_code)
            CH_H:    o_seg_c = SEG_H;
            CH_E:    o_seg_c = SEG_E;
            CH_L:    o_seg_c = SEG_L;
            CH_O:    o_seg_c = SEG_O;
            CH_F:    o_seg_c = SEG_F;
            CH_P:    o_seg_c = SEG_P;
            CH_G:    o_seg_c = SEG_G;
            CH_A:    o_seg_c = SEG_A;
            CH_DASH: o_seg_c = SEG_DASH;
            default: o_seg_c = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/window_digit_scanner.sv
// Multiplexed seven-segment scanner: latches the window index once per frame and
// shows msg[(win_lat + digit) mod MSG_LEN] on each digit with a blank guard cycle.
module window_digit_scanner
    import display_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned SCAN_DIV   = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIN_W-1:0]      win_idx,
    input  logic                  display_en,
    output logic [NUM_DIGITS-1:0] an,
    output logic [SEG_W-1:0]      seg,
    output logic                  dp,
    output logic                  frame_start
);

    localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]      r_scan_cnt;
    logic [DIG_W-1:0]      r_digit;
    logic [WIN_W-1:0]      r_win_lat;
    logic [NUM_DIGITS-1:0] r_an;
    logic [SEG_W-1:0]      r_seg;
    logic                  r_frame_start;

    logic                  w_term;
    logic                  w_frame_end;
    logic [4:0]            w_sum;
    logic [WIN_W-1:0]      w_idx;
    char_code_e            w_char;
    logic [SEG_W-1:0]      w_seg_c;
    logic [NUM_DIGITS-1:0] w_an_sel;

    assign w_term      = (r_scan_cnt == CNT_LAST);
    assign w_frame_end = w_term && (r_digit == DIG_LAST);

    // digit < MSG_LEN, so one conditional subtraction replaces the modulo.
    assign w_sum  = 5'(r_win_lat) + 5'(r_digit);
    assign w_idx  = (w_sum >= 5'(MSG_LEN)) ? WIN_W'(w_sum - 5'(MSG_LEN)) : WIN_W'(w_sum);
    assign w_char = MSG[w_idx];

    assign w_an_sel = ~(NUM_DIGITS'(1) << r_digit);

    char_seg_decoder u_dec (
        .i_code  (w_char),
        .o_seg_c (w_seg_c)
    );

    // Slot counter, digit counter and per-frame window latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scan_cnt <= '0;
            r_digit    <= '0;
            r_win_lat  <= '0;
        end else begin
            r_scan_cnt <= w_term ? '0 : r_scan_cnt + CNT_W'(1);
            if (w_term) begin
                r_digit <= (r_digit == DIG_LAST) ? '0 : r_digit + DIG_W'(1);
            end
            if (w_frame_end) begin
                r_win_lat <= (win_idx >= WIN_W'(MSG_LEN)) ? '0 : win_idx;
            end
        end
    end

    // Pin registers; scan_cnt == 0 is the ghost-guard slot with all anodes off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_an          <= '1;
            r_seg         <= SEG_BLANK;
            r_frame_start <= 1'b0;
        end else begin
            r_seg         <= w_seg_c;
            r_an          <= ((r_scan_cnt == '0) || !display_en) ? '1 : w_an_sel;
            r_frame_start <= w_frame_end;
        end
    end

    assign an          = r_an;
    assign seg         = r_seg;
    assign dp          = 1'b1;
    assign frame_start = r_frame_start;

endmodule
